// File: rtl/sign_expander_pkg.sv
// Shared widths and a reusable sign-extension helper for the sign_expander block.
package sign_expander_pkg;

  localparam int unsigned SE_IN_W  = 4;
  localparam int unsigned SE_OUT_W = 8;

  // Extends the low in_w bits of value to 64 bits; callers keep the slice they need.
  function automatic logic [63:0] sign_extend(input logic [63:0] value,
                                              input int unsigned in_w);
    logic [63:0] result;
    result = value;
    for (int unsigned i = in_w; i < 64; i++) begin
      result[i] = value[in_w-1];
    end
    return result;
  endfunction

endpackage

// File: rtl/sign_ext_comb.sv
// Purely combinational two's-complement widening from IN_W to OUT_W bits.
module sign_ext_comb
  import sign_expander_pkg::*;
#(
  parameter int unsigned IN_W  = SE_IN_W,
  parameter int unsigned OUT_W = SE_OUT_W
) (
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] z
);

  // A signed size cast also covers OUT_W == IN_W, where no replication field exists.
  always_comb begin
    z = OUT_W'($signed(a));
  end

endmodule

// File: rtl/sign_expander.sv
// Sign extender with a one-cycle output register; define SIGN_EXPANDER_BYPASS_EN
// to drop the register and drive o_Z combinationally from i_A.
module sign_expander
  import sign_expander_pkg::*;
#(
  parameter int unsigned IN_W  = SE_IN_W,
  parameter int unsigned OUT_W = SE_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  i_A,
  output logic [OUT_W-1:0] o_Z
);

  if (OUT_W < IN_W || IN_W < 1) begin : g_bad_width
    $error("sign_expander: requires IN_W >= 1 and OUT_W >= IN_W");
  end

  logic [OUT_W-1:0] ext;

  sign_ext_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_comb (
    .a (i_A),
    .z (ext)
  );

`ifdef SIGN_EXPANDER_BYPASS_EN
  // Clock and reset stay on the port list so instantiations are unchanged.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign o_Z = ext;
`else
  logic [OUT_W-1:0] z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
    end else begin
      z_q <= ext;
    end
  end

  assign o_Z = z_q;
`endif

endmodule

// File: tb/tb_sign_expander.sv
// Directed bench for sign_expander: default widths, reset behaviour, width corners
// and a random sweep at 5->16 bits; follows SIGN_EXPANDER_BYPASS_EN when defined.
module tb_sign_expander;
  import sign_expander_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a4;
  logic [7:0]  z4;
  logic [7:0]  a8;
  logic [7:0]  z8;
  logic [0:0]  a1;
  logic [7:0]  z1;
  logic [4:0]  a5;
  logic [15:0] z16;

  int unsigned checks;
  int unsigned errors;

  sign_expander #(.IN_W(4), .OUT_W(8))  dut_4_8  (.clk(clk), .rst_n(rst_n), .i_A(a4), .o_Z(z4));
  sign_expander #(.IN_W(8), .OUT_W(8))  dut_8_8  (.clk(clk), .rst_n(rst_n), .i_A(a8), .o_Z(z8));
  sign_expander #(.IN_W(1), .OUT_W(8))  dut_1_8  (.clk(clk), .rst_n(rst_n), .i_A(a1), .o_Z(z1));
  sign_expander #(.IN_W(5), .OUT_W(16)) dut_5_16 (.clk(clk), .rst_n(rst_n), .i_A(a5), .o_Z(z16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Registered build: settle past the next rising edge; bypass build: just a delta.
  task automatic settle();
`ifdef SIGN_EXPANDER_BYPASS_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
  endtask

  logic [7:0]  exp4 [16];
  logic [63:0] ref64;

  initial begin
    checks = 0;
    errors = 0;
    exp4 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
             8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    rst_n = 1'b0;
    a4 = 4'b1101;
    a8 = 8'h00;
    a1 = 1'b0;
    a5 = 5'd0;
    #2;
`ifdef SIGN_EXPANDER_BYPASS_EN
    check("bypass_rst_ignored", 64'(z4), 64'h00FD);
    a4 = 4'b1100;
    #1;
    check("bypass_no_edge", 64'(z4), 64'h00FC);
    rst_n = 1'b1;
    #1;
    check("bypass_rst_release", 64'(z4), 64'h00FC);
    rst_n = 1'b0;
    #1;
    check("bypass_rst_assert", 64'(z4), 64'h00FC);
    rst_n = 1'b1;
`else
    check("reset_held", 64'(z4), 64'h0000);
    @(posedge clk);
    #1;
    check("reset_held_edge", 64'(z4), 64'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_released_no_edge", 64'(z4), 64'h0000);
    @(posedge clk);
    #1;
    check("reset_release_load", 64'(z4), 64'h00FD);
`endif

    for (int unsigned v = 0; v < 16; v++) begin
      a4 = 4'(v);
      settle();
      check($sformatf("sweep_%0d", v), 64'(z4), 64'(exp4[v]));
    end

    a4 = 4'b1001;
    settle();
    check("mid_pre_reset", 64'(z4), 64'h00F9);
`ifndef SIGN_EXPANDER_BYPASS_EN
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_async_clear", 64'(z4), 64'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    a4 = 4'b0101;
    @(posedge clk);
    #1;
    check("mid_after_release", 64'(z4), 64'h0005);
`endif

    a8 = 8'h80;
    settle();
    check("w8_8_min", 64'(z8), 64'h0080);
    a8 = 8'h7F;
    settle();
    check("w8_8_max", 64'(z8), 64'h007F);
    a1 = 1'b1;
    settle();
    check("w1_8_one", 64'(z1), 64'h00FF);
    a1 = 1'b0;
    settle();
    check("w1_8_zero", 64'(z1), 64'h0000);

    a5 = 5'b10000;
    settle();
    check("w5_16_min", 64'(z16), 64'hFFF0);
    a5 = 5'b01111;
    settle();
    check("w5_16_max", 64'(z16), 64'h000F);

    for (int unsigned n = 0; n < 1000; n++) begin
      a5 = 5'($urandom_range(0, 31));
      settle();
      ref64 = sign_extend(64'(a5), 5);
      check("w5_16_random", 64'(z16), 64'(ref64[15:0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
